// File: rtl/nn_weight_loader_pkg.sv
// nn_weight_loader_pkg
// Shared definitions for the weight loader slice: the loader state
// encoding, the default per-layer geometry of the four-layer network,
// and the widths used for layer indices and neuron/weight counters.
package nn_weight_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_B,
    ST_NEXT,
    ST_DONE
  } loader_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_L1_NN      = 30;
  localparam int DEF_L1_NW      = 784;
  localparam int DEF_L2_NN      = 30;
  localparam int DEF_L2_NW      = 30;
  localparam int DEF_L3_NN      = 10;
  localparam int DEF_L3_NW      = 30;
  localparam int DEF_L4_NN      = 10;
  localparam int DEF_L4_NW      = 10;

  localparam int NUM_LAYERS = 4;
  localparam int LAYER_W    = 3;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/nn_layer_table.sv
// nn_layer_table
// Combinational lookup from a 1-based layer index to that layer's
// neuron count (nn) and weights-per-neuron (nw).
// Ports:
//   layer : layer index, 1..4
//   nn    : neuron count of the selected layer
//   nw    : weights per neuron of the selected layer
module nn_layer_table
  import nn_weight_loader_pkg::*;
#(
  parameter int L1_NN = DEF_L1_NN,
  parameter int L1_NW = DEF_L1_NW,
  parameter int L2_NN = DEF_L2_NN,
  parameter int L2_NW = DEF_L2_NW,
  parameter int L3_NN = DEF_L3_NN,
  parameter int L3_NW = DEF_L3_NW,
  parameter int L4_NN = DEF_L4_NN,
  parameter int L4_NW = DEF_L4_NW
) (
  input  logic [LAYER_W-1:0] layer,
  output logic [CNT_W-1:0]   nn,
  output logic [CNT_W-1:0]   nw
);

  // Out-of-range indices fall back to layer 1; the loader never produces them.
  always_comb begin
    nn = CNT_W'(L1_NN);
    nw = CNT_W'(L1_NW);
    case (layer)
      LAYER_W'(2): begin
        nn = CNT_W'(L2_NN);
        nw = CNT_W'(L2_NW);
      end
      LAYER_W'(3): begin
        nn = CNT_W'(L3_NN);
        nw = CNT_W'(L3_NW);
      end
      LAYER_W'(4): begin
        nn = CNT_W'(L4_NN);
        nw = CNT_W'(L4_NW);
      end
      default: begin
        nn = CNT_W'(L1_NN);
        nw = CNT_W'(L1_NW);
      end
    endcase
  end

endmodule

// File: rtl/nn_weight_loader.sv
// nn_weight_loader
// Streams a flat sequence of configuration words onto the shared layer
// configuration bus: for every neuron of every layer, its weights and then
// its bias, tagged with the layer/neuron being addressed. Inference input is
// gated off until a complete model has been loaded.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, abort          : begin a load (ignored while busy) / cancel a load
//   cfg_data/valid/ready  : configuration word stream (valid/ready handshake)
//   weight_value/valid    : weight word and one-cycle strobe to the layers
//   bias_value/valid      : bias word and one-cycle strobe to the layers
//   config_layer_num      : layer being loaded, 1..4
//   config_neuron_num     : neuron being loaded, 0-based
//   busy, done            : load in progress / full model loaded (sticky)
//   x_in_valid/data       : inference sample from upstream
//   x_out_valid/data      : gated inference sample (valid only once done)
module nn_weight_loader
  import nn_weight_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int L1_NN      = DEF_L1_NN,
  parameter int L1_NW      = DEF_L1_NW,
  parameter int L2_NN      = DEF_L2_NN,
  parameter int L2_NW      = DEF_L2_NW,
  parameter int L3_NN      = DEF_L3_NN,
  parameter int L3_NW      = DEF_L3_NW,
  parameter int L4_NN      = DEF_L4_NN,
  parameter int L4_NW      = DEF_L4_NW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [DATA_WIDTH-1:0] weight_value,
  output logic                  weight_valid,
  output logic [DATA_WIDTH-1:0] bias_value,
  output logic                  bias_valid,
  output logic [CNT_W-1:0]      config_layer_num,
  output logic [CNT_W-1:0]      config_neuron_num,
  output logic                  busy,
  output logic                  done,
  input  logic                  x_in_valid,
  input  logic [DATA_WIDTH-1:0] x_in_data,
  output logic                  x_out_valid,
  output logic [DATA_WIDTH-1:0] x_out_data
);

  loader_state_t    state;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] cur_nn;
  logic [CNT_W-1:0] cur_nw;
  logic             accept;

  nn_layer_table #(
    .L1_NN(L1_NN), .L1_NW(L1_NW),
    .L2_NN(L2_NN), .L2_NW(L2_NW),
    .L3_NN(L3_NN), .L3_NW(L3_NW),
    .L4_NN(L4_NN), .L4_NW(L4_NW)
  ) u_table (
    .layer (config_layer_num[LAYER_W-1:0]),
    .nn    (cur_nn),
    .nw    (cur_nw)
  );

  // Ready is withdrawn during an abort so a word offered in that cycle is
  // not consumed by the producer while the loader throws it away.
  assign cfg_ready   = ((state == ST_LOAD_W) || (state == ST_LOAD_B)) && !abort;
  assign accept      = cfg_valid && cfg_ready;
  assign busy        = (state == ST_LOAD_W) || (state == ST_LOAD_B) || (state == ST_NEXT);
  assign x_out_valid = x_in_valid && done;
  assign x_out_data  = x_in_data;

  // done is raised on leaving the final NEXT so it is visible in the DONE
  // cycle itself; layer/neuron only move at the end of NEXT, which keeps
  // them stable under every weight and bias strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      wcnt              <= '0;
      config_layer_num  <= CNT_W'(1);
      config_neuron_num <= '0;
      weight_value      <= '0;
      weight_valid      <= 1'b0;
      bias_value        <= '0;
      bias_valid        <= 1'b0;
      done              <= 1'b0;
    end else begin
      weight_valid <= 1'b0;
      bias_valid   <= 1'b0;
      if (abort) begin
        state             <= ST_IDLE;
        wcnt              <= '0;
        config_layer_num  <= CNT_W'(1);
        config_neuron_num <= '0;
        done              <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state             <= ST_LOAD_W;
              wcnt              <= '0;
              config_layer_num  <= CNT_W'(1);
              config_neuron_num <= '0;
              done              <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_LOAD_W: begin
            if (accept) begin
              weight_value <= cfg_data;
              weight_valid <= 1'b1;
              if (wcnt == cur_nw - CNT_W'(1)) begin
                wcnt  <= '0;
                state <= ST_LOAD_B;
              end else begin
                wcnt <= wcnt + CNT_W'(1);
              end
            end
          end
          ST_LOAD_B: begin
            if (accept) begin
              bias_value <= cfg_data;
              bias_valid <= 1'b1;
              state      <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (config_neuron_num < cur_nn - CNT_W'(1)) begin
              config_neuron_num <= config_neuron_num + CNT_W'(1);
              state             <= ST_LOAD_W;
            end else if (config_layer_num < CNT_W'(NUM_LAYERS)) begin
              config_layer_num  <= config_layer_num + CNT_W'(1);
              config_neuron_num <= '0;
              state             <= ST_LOAD_W;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nn_weight_loader.sv
// tb_nn_weight_loader
// Drives randomized configuration streams into a small loader (layer 1 is
// 2 neurons x 3 weights, layers 2..4 are 2 x 2, 26 words per load) and
// compares every weight/bias strobe against a list of expected
// (kind, layer, neuron, value) tuples built directly from the network shape.
module tb_nn_weight_loader;

  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [DW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [DW-1:0] weight_value;
  logic          weight_valid;
  logic [DW-1:0] bias_value;
  logic          bias_valid;
  logic [15:0]   config_layer_num;
  logic [15:0]   config_neuron_num;
  logic          busy;
  logic          done;
  logic          x_in_valid;
  logic [DW-1:0] x_in_data;
  logic          x_out_valid;
  logic [DW-1:0] x_out_data;

  nn_weight_loader #(
    .DATA_WIDTH(DW),
    .L1_NN(2), .L1_NW(3),
    .L2_NN(2), .L2_NW(2),
    .L3_NN(2), .L3_NW(2),
    .L4_NN(2), .L4_NW(2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .cfg_data          (cfg_data),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .weight_value      (weight_value),
    .weight_valid      (weight_valid),
    .bias_value        (bias_value),
    .bias_valid        (bias_valid),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .busy              (busy),
    .done              (done),
    .x_in_valid        (x_in_valid),
    .x_in_data         (x_in_data),
    .x_out_valid       (x_out_valid),
    .x_out_data        (x_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_bias;
    int          layer;
    int          neuron;
    logic [15:0] value;
    int          cycle;
    logic        ready;
  } pulse_t;

  pulse_t      obs_q[$];
  pulse_t      exp_q[$];
  logic [15:0] words[$];
  pulse_t      mon_p;
  int          cycle;
  int          done_rise_cycle;
  logic        done_q;

  int tests_run;
  int tests_failed;

  function automatic int nn_of(input int l);
    return 2;
  endfunction

  function automatic int nw_of(input int l);
    return (l == 1) ? 3 : 2;
  endfunction

  // Strobe monitor: records every weight/bias strobe with its tag and cycle.
  initial begin
    cycle           = 0;
    done_rise_cycle = -1;
    done_q          = 1'b0;
  end

  always @(negedge clk) begin
    cycle = cycle + 1;
    if (weight_valid === 1'b1) begin
      mon_p.is_bias = 1'b0;
      mon_p.layer   = int'(config_layer_num);
      mon_p.neuron  = int'(config_neuron_num);
      mon_p.value   = weight_value;
      mon_p.cycle   = cycle;
      mon_p.ready   = cfg_ready;
      obs_q.push_back(mon_p);
    end
    if (bias_valid === 1'b1) begin
      mon_p.is_bias = 1'b1;
      mon_p.layer   = int'(config_layer_num);
      mon_p.neuron  = int'(config_neuron_num);
      mon_p.value   = bias_value;
      mon_p.cycle   = cycle;
      mon_p.ready   = cfg_ready;
      obs_q.push_back(mon_p);
    end
    if (done === 1'b1 && done_q !== 1'b1) done_rise_cycle = cycle;
    done_q = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Reference model: the stream is neuron-major within each layer, NW weights
  // then one bias per neuron, layers 1..4 in order.
  task automatic make_load();
    pulse_t e;
    words.delete();
    exp_q.delete();
    for (int l = 1; l <= 4; l++) begin
      for (int n = 0; n < nn_of(l); n++) begin
        for (int w = 0; w <= nw_of(l); w++) begin
          e.is_bias = (w == nw_of(l));
          e.layer   = l;
          e.neuron  = n;
          e.value   = 16'($urandom);
          e.cycle   = 0;
          e.ready   = 1'b0;
          words.push_back(e.value);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers words[0..n-1]; with gaps set, cfg_valid drops randomly.
  // start_at >= 0 raises start while that word is being offered.
  task automatic send_words(input int n, input bit gaps, input int start_at);
    int idx;
    int budget;
    bit acc;
    idx    = 0;
    budget = 0;
    while (idx < n && budget < 2000) begin
      cfg_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      cfg_data  = words[idx];
      start     = (idx == start_at);
      @(negedge clk);
      acc = (cfg_valid === 1'b1) && (cfg_ready === 1'b1);
      tick();
      if (acc) idx++;
      budget++;
    end
    cfg_valid = 1'b0;
    start     = 1'b0;
    if (idx < n) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL send_words: only %0d of %0d words accepted", idx, n);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    x_in_valid = 1'b1;
    x_in_data  = 16'h0042;
    repeat (3) tick();
    reset = 1'b0;
    sample();
    tests_run++;
    if ({busy, done, cfg_ready, weight_valid, bias_valid} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b required 00000", {busy, done, cfg_ready, weight_valid, bias_valid});
    end
    tests_run++;
    if (config_layer_num !== 16'd1 || config_neuron_num !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_layer_neuron: got %0d/%0d required 1/0", config_layer_num, config_neuron_num);
    end
    tests_run++;
    if (weight_value !== 16'h0 || bias_value !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got %h/%h required 0000/0000", weight_value, bias_value);
    end
    tests_run++;
    if (x_out_valid !== 1'b0 || x_out_data !== 16'h0042) begin
      tests_failed++;
      $display("[TB] FAIL gate_before_done: got valid=%b data=%h required valid=0 data=0042", x_out_valid, x_out_data);
    end
  endtask

  task automatic test_full_load(input bit gaps, input int start_at, input string name);
    int     base;
    int     n_obs;
    int     k;
    pulse_t o;
    pulse_t e;
    make_load();
    base       = obs_q.size();
    x_in_valid = 1'b1;
    x_in_data  = 16'($urandom);
    pulse_start();
    sample();
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0 || cfg_ready !== 1'b1 || x_out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_after_start: got busy=%b done=%b ready=%b xv=%b required 1 0 1 0", name, busy, done, cfg_ready, x_out_valid);
    end
    tick();
    send_words(exp_q.size(), gaps, start_at);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      sample();
      k++;
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s_done: got %b required 1 within 20 cycles", name, done);
    end
    n_obs = obs_q.size() - base;
    tests_run++;
    if (n_obs != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL %s_pulse_count: got %0d required %0d", name, n_obs, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
      o = obs_q[base + i];
      e = exp_q[i];
      tests_run++;
      if (o.is_bias != e.is_bias || o.layer != e.layer || o.neuron != e.neuron || o.value !== e.value) begin
        tests_failed++;
        $display("[TB] FAIL %s_pulse%0d: got bias=%0b L%0d N%0d v=%h required bias=%0b L%0d N%0d v=%h",
                 name, i, o.is_bias, o.layer, o.neuron, o.value, e.is_bias, e.layer, e.neuron, e.value);
      end
      if (e.is_bias) begin
        tests_run++;
        if (o.ready !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL %s_ready_in_next%0d: got %b required 0", name, i, o.ready);
        end
      end
    end
    if (n_obs > 0) begin
      tests_run++;
      if (done_rise_cycle != obs_q[obs_q.size() - 1].cycle + 1) begin
        tests_failed++;
        $display("[TB] FAIL %s_done_timing: got cycle %0d required %0d", name, done_rise_cycle, obs_q[obs_q.size() - 1].cycle + 1);
      end
    end
    sample();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s_idle_after: got busy=%b done=%b required 0 1", name, busy, done);
    end
  endtask

  task automatic test_gate();
    x_in_valid = 1'b1;
    x_in_data  = 16'h0042;
    sample();
    tests_run++;
    if (x_out_valid !== 1'b1 || x_out_data !== 16'h0042) begin
      tests_failed++;
      $display("[TB] FAIL gate_after_done: got valid=%b data=%h required valid=1 data=0042", x_out_valid, x_out_data);
    end
    x_in_valid = 1'b0;
    sample();
    tests_run++;
    if (x_out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL gate_in_low: got %b required 0", x_out_valid);
    end
    x_in_valid = 1'b1;
  endtask

  task automatic test_abort();
    int base;
    make_load();
    pulse_start();
    send_words(5, 1'b0, -1);
    abort     = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = words[5];
    sample();
    base = obs_q.size();
    tick();
    abort     = 1'b0;
    cfg_valid = 1'b0;
    sample();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_flags: got busy=%b done=%b ready=%b required 0 0 0", busy, done, cfg_ready);
    end
    tests_run++;
    if (config_layer_num !== 16'd1 || config_neuron_num !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_counters: got %0d/%0d required 1/0", config_layer_num, config_neuron_num);
    end
    tests_run++;
    if (obs_q.size() != base || weight_valid !== 1'b0 || bias_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_pulse: got %0d new strobes required 0", obs_q.size() - base);
    end
    test_full_load(1'b0, -1, "after_abort");
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sample();
    tests_run++;
    if (done !== 1'b0 || x_out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_clears_done: got done=%b xv=%b required 0 0", done, x_out_valid);
    end
  endtask

  task automatic test_reset_mid_load();
    int base;
    make_load();
    pulse_start();
    send_words(3, 1'b0, -1);
    reset     = 1'b1;
    start     = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = words[3];
    sample();
    base = obs_q.size();
    tick();
    reset     = 1'b0;
    start     = 1'b0;
    cfg_valid = 1'b0;
    sample();
    tests_run++;
    if ({busy, done, cfg_ready, weight_valid, bias_valid} !== 5'b0 || obs_q.size() != base) begin
      tests_failed++;
      $display("[TB] FAIL midload_reset_flags: got %b strobes=%0d required 00000 strobes=0",
               {busy, done, cfg_ready, weight_valid, bias_valid}, obs_q.size() - base);
    end
    tests_run++;
    if (config_layer_num !== 16'd1 || config_neuron_num !== 16'd0 || weight_value !== 16'h0 || bias_value !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL midload_reset_regs: got L%0d N%0d w=%h b=%h required L1 N0 w=0000 b=0000",
               config_layer_num, config_neuron_num, weight_value, bias_value);
    end
    sample();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midload_reset_stays_idle: got busy=%b required 0", busy);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_full_load(1'b0, -1, "full_load");
    test_gate();
    test_full_load(1'b1, -1, "back_pressure");
    test_full_load(1'b0, 10, "start_while_busy");
    test_full_load(1'b1, 4, "start_busy_gaps");
    test_abort();
    test_reset_mid_load();
    for (int r = 0; r < 3; r++) test_full_load(1'b1, -1, "random_load");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
